stage_mem: RTL and testbench

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem.sv | 191 +++++++++++++++++++
 tb/tb_stage_mem.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// Memory stage: turns load/store requests from execute into a single outstanding
// data-memory transaction, and registers the write-back result for the next stage.
module stage_mem #(
  parameter int WD_SIZE        = 32,
  parameter int INSTR_REG_SIZE = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ctrl_ld_i,
  input  logic                      ctrl_st_i,
  input  logic                      ctrl_reg_write_i,
  input  logic [2:0]                ctrl_mem_width_i,
  input  logic [WD_SIZE-1:0]        alu_result_i,
  input  logic [WD_SIZE-1:0]        rs2_data_i,
  input  logic [INSTR_REG_SIZE-1:0] rd_i,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [WD_SIZE-1:0]        dmem_addr_o,
  output logic [3:0]                dmem_be_o,
  output logic [WD_SIZE-1:0]        dmem_wdata_o,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  input  logic [WD_SIZE-1:0]        dmem_rdata_i,
  output logic                      stall_proc_o,
  output logic [WD_SIZE-1:0]        wb_data_o,
  output logic [INSTR_REG_SIZE-1:0] rd_o,
  output logic                      ctrl_reg_write_o,
  output logic                      misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  state_e                    state_q, state_d;
  logic [WD_SIZE-1:0]        addr_q, addr_d;
  logic [3:0]                be_q, be_d;
  logic [WD_SIZE-1:0]        wdata_q, wdata_d;
  logic [2:0]                width_q, width_d;
  logic [INSTR_REG_SIZE-1:0] rd_cap_q, rd_cap_d;
  logic                      rw_cap_q, rw_cap_d;
  logic                      load_q, load_d;
  logic [WD_SIZE-1:0]        wb_data_q, wb_data_d;
  logic [INSTR_REG_SIZE-1:0] rd_q, rd_d;
  logic                      reg_write_q, reg_write_d;
  logic                      misalign_q, misalign_d;

  logic                      stall_c;
  logic [1:0]                size_c;
  logic                      bad_access_c;
  logic [3:0]                be_new_c;
  logic [WD_SIZE-1:0]        wdata_new_c;
  logic [7:0]                ld_byte_c;
  logic [15:0]               ld_half_c;
  logic [WD_SIZE-1:0]        ld_data_c;

  // Decode the incoming access: lane enables, lane-placed store data and legality.
  always_comb begin
    size_c       = ctrl_mem_width_i[1:0];
    bad_access_c = 1'b0;
    be_new_c     = 4'b1111;
    wdata_new_c  = rs2_data_i;
    case (size_c)
      2'b00: begin
        be_new_c    = 4'b0001 << alu_result_i[1:0];
        wdata_new_c = {(WD_SIZE/8){rs2_data_i[7:0]}};
      end
      2'b01: begin
        be_new_c     = 4'b0011 << alu_result_i[1:0];
        wdata_new_c  = {(WD_SIZE/16){rs2_data_i[15:0]}};
        bad_access_c = alu_result_i[0];
      end
      2'b10:   bad_access_c = ctrl_mem_width_i[2] || (alu_result_i[1:0] != 2'b00);
      default: bad_access_c = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte_c = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half_c = dmem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (width_q)
      3'b000:  ld_data_c = {{(WD_SIZE-8){ld_byte_c[7]}}, ld_byte_c};
      3'b100:  ld_data_c = {{(WD_SIZE-8){1'b0}}, ld_byte_c};
      3'b001:  ld_data_c = {{(WD_SIZE-16){ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_data_c = {{(WD_SIZE-16){1'b0}}, ld_half_c};
      default: ld_data_c = dmem_rdata_i;
    endcase
  end

  // Write-back and misalign are single-cycle pulses unless explicitly set below.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    width_d     = width_q;
    rd_cap_d    = rd_cap_q;
    rw_cap_d    = rw_cap_q;
    load_d      = load_q;
    wb_data_d   = wb_data_q;
    rd_d        = rd_q;
    reg_write_d = 1'b0;
    misalign_d  = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_ld_i || ctrl_st_i) begin
          if (bad_access_c) begin
            misalign_d = 1'b1;
          end else begin
            addr_d   = alu_result_i;
            be_d     = be_new_c;
            wdata_d  = wdata_new_c;
            width_d  = ctrl_mem_width_i;
            rd_cap_d = rd_i;
            rw_cap_d = ctrl_reg_write_i;
            load_d   = ctrl_ld_i;
            state_d  = REQ;
            stall_c  = 1'b1;
          end
        end else begin
          wb_data_d   = alu_result_i;
          rd_d        = rd_i;
          reg_write_d = ctrl_reg_write_i;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (dmem_gnt_i) begin
          if (load_q) begin
            state_d = RSP;
          end else begin
            state_d = IDLE;
            stall_c = 1'b0;
          end
        end
      end
      RSP: begin
        stall_c = !dmem_rvalid_i;
        if (dmem_rvalid_i) begin
          wb_data_d   = ld_data_c;
          rd_d        = rd_cap_q;
          reg_write_d = rw_cap_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      width_q     <= '0;
      rd_cap_q    <= '0;
      rw_cap_q    <= 1'b0;
      load_q      <= 1'b0;
      wb_data_q   <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      width_q     <= width_d;
      rd_cap_q    <= rd_cap_d;
      rw_cap_q    <= rw_cap_d;
      load_q      <= load_d;
      wb_data_q   <= wb_data_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      misalign_q  <= misalign_d;
    end
  end

  // Bus outputs come only from captured state, so they stay stable until granted.
  assign dmem_req_o       = (state_q == REQ);
  assign dmem_we_o        = dmem_req_o && !load_q;
  assign dmem_addr_o      = dmem_req_o ? {addr_q[WD_SIZE-1:2], 2'b00} : '0;
  assign dmem_be_o        = dmem_req_o ? be_q : 4'b0000;
  assign dmem_wdata_o     = dmem_req_o ? wdata_q : '0;
  assign stall_proc_o     = stall_c && !reset;
  assign wb_data_o        = wb_data_q;
  assign rd_o             = rd_q;
  assign ctrl_reg_write_o = reg_write_q;
  assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed and randomized loads/stores checked against a
// byte-lane arithmetic model of the memory stage.
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_ld_i, ctrl_st_i, ctrl_reg_write_i;
  logic [2:0]  ctrl_mem_width_i;
  logic [31:0] alu_result_i, rs2_data_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_proc_o;
  logic [31:0] wb_data_o;
  logic [4:0]  rd_o;
  logic        ctrl_reg_write_o, misalign_o;

  int errors = 0;
  int checks = 0;

  stage_mem #(.WD_SIZE(32), .INSTR_REG_SIZE(5)) dut (
    .clk(clk), .reset(reset),
    .ctrl_ld_i(ctrl_ld_i), .ctrl_st_i(ctrl_st_i), .ctrl_reg_write_i(ctrl_reg_write_i),
    .ctrl_mem_width_i(ctrl_mem_width_i), .alu_result_i(alu_result_i),
    .rs2_data_i(rs2_data_i), .rd_i(rd_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_proc_o(stall_proc_o), .wb_data_o(wb_data_o), .rd_o(rd_o),
    .ctrl_reg_write_o(ctrl_reg_write_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes and legality straight from funct3.
  function automatic int m_bytes(input logic [2:0] w);
    case (w)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit m_illegal(input logic [2:0] w, input logic [31:0] a);
    case (w)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return (a % 2) != 0;
      3'b010:         return (a % 4) != 0;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] w, input logic [31:0] a);
    int mask;
    mask = ((1 << m_bytes(w)) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] w, input logic [31:0] d);
    if (m_bytes(w) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (m_bytes(w) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] w, input logic [31:0] a,
                                         input logic [31:0] rdata);
    logic [31:0] v, span;
    int n;
    n = m_bytes(w);
    if (n == 4) return rdata;
    span = 32'd1 << (8 * n);
    v = (rdata >> (8 * (a % 4))) % span;
    if (w[2] == 1'b0 && v >= span / 2) v = v - span;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ctrl_ld_i = 0; ctrl_st_i = 0; ctrl_reg_write_i = 0; ctrl_mem_width_i = 0;
    alu_result_i = 0; rs2_data_i = 0; rd_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
  endtask

  // Runs one ld/st from IDLE through to completion, checking every phase inline.
  task automatic run_access(input bit ld, input bit st, input logic [2:0] w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [4:0] rd, input bit rw,
                            input logic [31:0] rdata, input int gd, input int rdly);
    logic [31:0] exp_addr;
    ctrl_ld_i = ld; ctrl_st_i = st; ctrl_mem_width_i = w; alu_result_i = a;
    rs2_data_i = d; rd_i = rd; ctrl_reg_write_i = rw;
    dmem_gnt_i = 0; dmem_rvalid_i = 0;
    exp_addr = a - (a % 4);
    #1;
    if (m_illegal(w, a)) begin
      checks++;
      if (stall_proc_o !== 1'b0 || dmem_req_o !== 1'b0) begin
        errors++; $display("[TB] FAIL misalign_nostall: stall=%b req=%b required 0/0", stall_proc_o, dmem_req_o);
      end
      step();
      checks++;
      if (misalign_o !== 1'b1 || ctrl_reg_write_o !== 1'b0 || dmem_req_o !== 1'b0) begin
        errors++; $display("[TB] FAIL misalign_pulse: mis=%b rw=%b req=%b required 1/0/0", misalign_o, ctrl_reg_write_o, dmem_req_o);
      end
      clear_inputs();
      step();
      checks++;
      if (misalign_o !== 1'b0) begin
        errors++; $display("[TB] FAIL misalign_once: mis=%b required 0", misalign_o);
      end
      return;
    end
    checks++;
    if (stall_proc_o !== 1'b1 || dmem_req_o !== 1'b0) begin
      errors++; $display("[TB] FAIL accept: stall=%b req=%b required 1/0", stall_proc_o, dmem_req_o);
    end
    step();
    for (int i = 0; i <= gd; i++) begin
      dmem_rvalid_i = (i < gd) ? 1'b1 : 1'b0;
      dmem_rdata_i  = $urandom;
      dmem_gnt_i    = (i == gd);
      #1;
      checks++;
      if (dmem_req_o !== 1'b1 || dmem_addr_o !== exp_addr || dmem_we_o !== !ld ||
          dmem_be_o !== m_be(w, a) || ctrl_reg_write_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL req_phase: req=%b addr=%h we=%b be=%b rw=%b required 1/%h/%b/%b/0",
                 dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, ctrl_reg_write_o,
                 exp_addr, !ld, m_be(w, a));
      end
      if (!ld) begin
        checks++;
        if (dmem_wdata_o !== m_wdata(w, d)) begin
          errors++; $display("[TB] FAIL store_wdata: got %h required %h", dmem_wdata_o, m_wdata(w, d));
        end
      end
      checks++;
      if (stall_proc_o !== ((i < gd) || ld)) begin
        errors++; $display("[TB] FAIL req_stall: got %b required %b", stall_proc_o, (i < gd) || ld);
      end
      step();
    end
    dmem_gnt_i = 0; dmem_rvalid_i = 0;
    if (!ld) begin
      checks++;
      if (dmem_req_o !== 1'b0 || ctrl_reg_write_o !== 1'b0) begin
        errors++; $display("[TB] FAIL store_done: req=%b rw=%b required 0/0", dmem_req_o, ctrl_reg_write_o);
      end
      clear_inputs();
      return;
    end
    for (int i = 0; i <= rdly; i++) begin
      dmem_rvalid_i = (i == rdly);
      dmem_rdata_i  = (i == rdly) ? rdata : $urandom;
      #1;
      checks++;
      if (dmem_req_o !== 1'b0 || stall_proc_o !== (i != rdly)) begin
        errors++; $display("[TB] FAIL rsp_phase: req=%b stall=%b required 0/%b", dmem_req_o, stall_proc_o, i != rdly);
      end
      step();
    end
    dmem_rvalid_i = 0;
    checks++;
    if (wb_data_o !== m_load(w, a, rdata) || rd_o !== rd || ctrl_reg_write_o !== rw) begin
      errors++;
      $display("[TB] FAIL load_wb: wb=%h rd=%0d rw=%b required %h/%0d/%b",
               wb_data_o, rd_o, ctrl_reg_write_o, m_load(w, a, rdata), rd, rw);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    ctrl_ld_i = 1; ctrl_mem_width_i = 3'b010; alu_result_i = 32'h40;
    #3;
    checks++;
    if (dmem_req_o !== 0 || stall_proc_o !== 0 || wb_data_o !== 0 || rd_o !== 0 ||
        ctrl_reg_write_o !== 0 || misalign_o !== 0 || dmem_be_o !== 0) begin
      errors++; $display("[TB] FAIL reset_state: req=%b stall=%b wb=%h rd=%0d rw=%b mis=%b required all 0",
                         dmem_req_o, stall_proc_o, wb_data_o, rd_o, ctrl_reg_write_o, misalign_o);
    end
    step();
    clear_inputs();
    reset = 0;
    alu_result_i = 32'h55; rd_i = 3; ctrl_reg_write_i = 1;
    step();
    checks++;
    if (wb_data_o !== 32'h55 || rd_o !== 5'd3 || ctrl_reg_write_o !== 1'b1) begin
      errors++; $display("[TB] FAIL first_edge: wb=%h rd=%0d rw=%b required 00000055/3/1", wb_data_o, rd_o, ctrl_reg_write_o);
    end
    clear_inputs();
  endtask

  task automatic test_nonmem();
    alu_result_i = 32'h0000_1234; rd_i = 7; ctrl_reg_write_i = 1;
    #1;
    checks++;
    if (stall_proc_o !== 1'b0) begin
      errors++; $display("[TB] FAIL nonmem_stall: got %b required 0", stall_proc_o);
    end
    step();
    checks++;
    if (wb_data_o !== 32'h0000_1234 || rd_o !== 5'd7 || ctrl_reg_write_o !== 1'b1 || stall_proc_o !== 1'b0) begin
      errors++; $display("[TB] FAIL nonmem_wb: wb=%h rd=%0d rw=%b stall=%b required 00001234/7/1/0",
                         wb_data_o, rd_o, ctrl_reg_write_o, stall_proc_o);
    end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] v;
      logic [4:0]  r;
      logic        w;
      v = $urandom; r = 5'($urandom); w = 1'($urandom);
      alu_result_i = v; rd_i = r; ctrl_reg_write_i = w;
      step();
      checks++;
      if (wb_data_o !== v || rd_o !== r || ctrl_reg_write_o !== w) begin
        errors++; $display("[TB] FAIL nonmem_rand: wb=%h rd=%0d rw=%b required %h/%0d/%b", wb_data_o, rd_o, ctrl_reg_write_o, v, r, w);
      end
    end
    clear_inputs();
  endtask

  task automatic test_directed();
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 5'd9, 1, 32'h80FF_0000, 2, 0);
    run_access(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd4, 1, 32'h0, 0, 0);
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 5'd5, 1, 32'h0, 0, 0);
    run_access(1, 0, 3'b101, 32'h002, 32'h0, 5'd6, 1, 32'h9ABC_0000, 0, 0);
    run_access(1, 1, 3'b010, 32'h300, 32'h1111_2222, 5'd8, 1, 32'hCAFE_F00D, 1, 1);
    run_access(0, 1, 3'b011, 32'h400, 32'h5, 5'd1, 0, 32'h0, 0, 0);
    run_access(0, 1, 3'b000, 32'h501, 32'h1234_56A7, 5'd2, 0, 32'h0, 1, 0);
    run_access(1, 0, 3'b001, 32'h602, 32'h0, 5'd10, 1, 32'h8001_7FFF, 0, 2);
  endtask

  task automatic test_random();
    logic [2:0] wtab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      bit ld, st;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      run_access(ld, st, wtab[$urandom_range(0, 7)], a, $urandom, 5'($urandom), 1'($urandom),
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_rsp();
    ctrl_ld_i = 1; ctrl_mem_width_i = 3'b010; alu_result_i = 32'h40; rd_i = 12; ctrl_reg_write_i = 1;
    step();
    dmem_gnt_i = 1;
    step();
    dmem_gnt_i = 0;
    checks++;
    if (stall_proc_o !== 1'b1 || dmem_req_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rsp_wait: stall=%b req=%b required 1/0", stall_proc_o, dmem_req_o);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (dmem_req_o !== 0 || stall_proc_o !== 0 || wb_data_o !== 0 || rd_o !== 0 ||
        ctrl_reg_write_o !== 0 || misalign_o !== 0) begin
      errors++; $display("[TB] FAIL reset_in_rsp: req=%b stall=%b wb=%h rd=%0d rw=%b required all 0",
                         dmem_req_o, stall_proc_o, wb_data_o, rd_o, ctrl_reg_write_o);
    end
    step();
    clear_inputs();
    reset = 0;
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (stall_proc_o !== 1'b0) begin
      errors++; $display("[TB] FAIL late_rvalid_stall: got %b required 0", stall_proc_o);
    end
    step();
    dmem_rvalid_i = 0;
    checks++;
    if (ctrl_reg_write_o !== 0 || wb_data_o !== 0 || dmem_req_o !== 0) begin
      errors++; $display("[TB] FAIL late_rvalid: rw=%b wb=%h req=%b required 0/0/0", ctrl_reg_write_o, wb_data_o, dmem_req_o);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_nonmem();
    test_directed();
    test_random();
    test_reset_mid_rsp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
